// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 8N1, LSB first, idle-high line.
// Start, data and stop bits are each resolved by a 3-sample majority vote
// ending at the nominal mid-bit. The received byte is held in a one-entry
// buffer with a valid/ack handshake. Framing errors and overruns are flagged.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line idle, waiting for rx_s = 0
//   S_START | timing half a bit, then validating the start bit
//   S_DATA  | sampling 8 data bits, LSB first
//   S_STOP  | sampling the stop bit, delivering the byte or flagging error
//   S_BREAK | stop bit was 0, waiting for the line to return high
module uart_rx_os #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_ack,
    output logic [7:0] rxout,
    output logic       rx_valid,
    output logic       rxdone,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // Down-counter reload values; the sample point is where the count hits 0.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic [1:0]  hist_q, hist_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rxout_q, rxout_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rxdone_q, rxdone_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic        vote;
    logic        cnt_tc;

    // Majority of rx_s at sample point -2, -1 and 0 (hist_q holds the two previous samples).
    assign vote   = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
    assign cnt_tc = (cnt_q == '0);

    // All state registers; synchronizer and history reset to the idle-high level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            hist_q      <= 2'b11;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rxout_q     <= 8'h00;
            rx_valid_q  <= 1'b0;
            rxdone_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rxout_q     <= rxout_d;
            rx_valid_q  <= rx_valid_d;
            rxdone_q    <= rxdone_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state, bit timing, shifting and the delivery/handshake logic.
    always_comb begin
        state_d     = state_q;
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        hist_d      = {hist_q[0], rx_s_q};
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rxout_d     = rxout_q;
        rx_valid_d  = rx_valid_q;
        rxdone_d    = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        // The consumer ack is applied first so a same-cycle delivery can override rx_valid.
        if (rx_valid_q && rd_ack) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (cnt_tc) begin
                    if (vote) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        cnt_d     = BIT_LOAD;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_tc) begin
                    shift_d   = {vote, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_tc) begin
                    if (vote) begin
                        state_d = S_IDLE;
                        if (!rx_valid_q || rd_ack) begin
                            rxout_d    = shift_q;
                            rx_valid_d = 1'b1;
                            rxdone_d   = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        state_d     = S_BREAK;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rxout     = rxout_q;
    assign rx_valid  = rx_valid_q;
    assign rxdone    = rxdone_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: table of frames plus hand-written corner cases,
// with a scoreboard of expected deliveries and framing errors.
module tb_uart_rx_os;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] rxout;
    logic       rx_valid;
    logic       rxdone;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_os #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_ack    (rd_ack),
        .rxout     (rxout),
        .rx_valid  (rx_valid),
        .rxdone    (rxdone),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   ferr_q[$];

    typedef struct {
        logic [7:0] data;
        bit         ack_before;
        bit         ack_dlv;
        int         glitch_i;
        bit         exp_dlv;
        logic [7:0] exp_rxout;
        bit         exp_ov;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rxout"}, 32'(rxout), 32'h00);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_rxdone"}, 32'(rxdone), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard side: every rxdone / frame_err pulse is matched against the queues.
    always @(negedge clk) begin
        if (rxdone || frame_err)
            chk("rxdone_frame_err_exclusive", 32'(rxdone && frame_err), 32'd0);
        if (rxdone) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rxdone", 32'(rxdone), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rxout_at_rxdone", 32'(rxout), 32'(e.data));
                chk("rxdone_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (frame_err) begin
            if (ferr_q.size() == 0) begin
                chk("unexpected_frame_err", 32'(frame_err), 32'd0);
            end else begin
                int fc;
                fc = ferr_q.pop_front();
                chk("frame_err_cycle", 32'(cyc), 32'(fc));
            end
        end
    end

    // Drives one full 160-cycle frame starting now. rxdone/frame_err are
    // expected to be visible at the negedge 155 cycles after the falling edge
    // is driven (2 synchronizer cycles + 1 detect + H + 9 bits).
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input bit ack_dlv,
                              input int glitch_i, input bit exp_dlv, input int rst_i);
        int   n;
        exp_t e;
        n = cyc;
        if (exp_dlv) begin
            e.data = d;
            e.cyc  = n + 155;
            exp_q.push_back(e);
        end
        if (!stop_v) ferr_q.push_back(n + 155);
        for (int i = 0; i < 10 * CPB; i++) begin
            int   idx;
            logic b;
            idx = i / CPB;
            if (idx == 0)      b = 1'b0;
            else if (idx <= 8) b = d[idx-1];
            else               b = stop_v;
            if (i == glitch_i) b = ~b;
            rx = b;
            rd_ack = ack_dlv && (i == 154);
            if (i == rst_i) begin
                rst_n = 1'b0;
                #1;
                check_reset("mid_frame_reset");
            end
            if (i == rst_i + 1) rst_n = 1'b1;
            tick();
        end
        rd_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        @(negedge clk);
        chk("ack_clears_valid", 32'(rx_valid), 32'd0);
        chk("ack_clears_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;

        //            data   ackb ackd glitch dlv  exp_rxout ov
        vecs[0] = '{8'h00, 1'b1, 1'b0, 72, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{8'h11, 1'b1, 1'b0, -1, 1'b1, 8'h11, 1'b0};
        vecs[2] = '{8'h22, 1'b0, 1'b0, -1, 1'b0, 8'h11, 1'b1};
        vecs[3] = '{8'h33, 1'b1, 1'b0, -1, 1'b1, 8'h33, 1'b0};
        vecs[4] = '{8'h66, 1'b1, 1'b0, -1, 1'b1, 8'h66, 1'b0};
        vecs[5] = '{8'h77, 1'b0, 1'b1, -1, 1'b1, 8'h77, 1'b0};
        vecs[6] = '{8'h88, 1'b0, 1'b0, -1, 1'b0, 8'h77, 1'b1};
        vecs[7] = '{8'h99, 1'b0, 1'b1, -1, 1'b1, 8'h99, 1'b0};
        vecs[8] = '{8'hE7, 1'b1, 1'b0, -1, 1'b1, 8'hE7, 1'b0};

        #1 rst_n = 1'b0;
        #2;
        check_reset("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();

        // Ideal 0xA5 frame, then ack handshake timing.
        send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1, -1);
        repeat (20) tick();
        chk("a5_rxout_held", 32'(rxout), 32'hA5);
        chk("a5_valid_held", 32'(rx_valid), 32'd1);
        rd_ack = 1'b1;
        @(negedge clk);
        chk("a5_valid_before_ack_edge", 32'(rx_valid), 32'd1);
        tick();
        rd_ack = 1'b0;
        @(negedge clk);
        chk("a5_valid_after_ack", 32'(rx_valid), 32'd0);
        tick();

        // False start: 4-cycle low pulse; busy from T0+1 until T0+H+1.
        rx = 1'b0;
        n = cyc;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            chk("false_start_busy", 32'(busy), 32'((j >= 3) && (j <= 10)));
            tick();
            if (j == 3) rx = 1'b1;
        end
        chk("false_start_cycles", 32'(cyc - n), 32'd15);
        repeat (10) tick();
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b1, -1);
        chk("after_false_start_rxout", 32'(rxout), 32'h5A);

        // Table-driven frames, back-to-back where no ack is inserted.
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].ack_before) ack_pulse();
            send_frame(vecs[v].data, 1'b1, vecs[v].ack_dlv, vecs[v].glitch_i, vecs[v].exp_dlv, -1);
            @(negedge clk);
            chk($sformatf("vec%0d_rxout", v), 32'(rxout), 32'(vecs[v].exp_rxout));
            chk($sformatf("vec%0d_valid", v), 32'(rx_valid), 32'd1);
            chk($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ov));
        end

        // Framing error: stop bit low, line held low 40 cycles from stop start.
        send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0, -1);
        repeat (24) tick();
        rx = 1'b1;
        m = cyc;
        repeat (2) tick();
        @(negedge clk);
        chk("break_busy_before_exit", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        chk("break_exit_cycle", 32'(cyc - m), 32'd3);
        chk("break_busy_after_exit", 32'(busy), 32'd0);
        chk("ferr_rxout_unchanged", 32'(rxout), 32'hE7);
        chk("ferr_valid_unchanged", 32'(rx_valid), 32'd1);
        chk("ferr_overrun_unchanged", 32'(overrun), 32'd0);
        ack_pulse();
        send_frame(8'hC3, 1'b1, 1'b0, -1, 1'b1, -1);
        chk("after_ferr_rxout", 32'(rxout), 32'hC3);

        // Reset in the middle of data bit 4 of 0xFF, then 0x81.
        send_frame(8'hFF, 1'b1, 1'b0, -1, 1'b0, 88);
        repeat (5) tick();
        send_frame(8'h81, 1'b1, 1'b0, -1, 1'b1, -1);
        @(negedge clk);
        chk("after_reset_rxout", 32'(rxout), 32'h81);
        chk("after_reset_valid", 32'(rx_valid), 32'd1);

        repeat (20) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("ferr_queue_drained", 32'(ferr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
